iot_feeder: RTL and testbench

IOT_FEEDER -- requirements
Module: iot_feeder

---
 rtl/iot_feeder_if.sv | 22 ++
 rtl/iot_feeder.sv | 112 +++++++++++
 tb/tb_iot_feeder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iot_feeder_if.sv
// Byte feeder port bundle: 128-bit word intake plus
// the byte stream toward the downstream processing stage.
interface iot_feeder_if;
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_ready;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;
  logic         round_done;
  logic         active;

  modport master (
    output s_valid, s_data, busy,
    input  s_ready, in_en, iot_in, round_done, active
  );

  modport slave (
    input  s_valid, s_data, busy,
    output s_ready, in_en, iot_in, round_done, active
  );
endinterface

// File: rtl/iot_feeder.sv
// Word FIFO feeding a 128-bit word out as 16 bytes, MSB first,
// with downstream backpressure and per-round completion pulse.
module iot_feeder #(
  parameter int DEPTH       = 4,
  parameter int ROUND_WORDS = 8
) (
  input logic         clk,
  input logic         rst,
  iot_feeder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (ROUND_WORDS > 1) ? $clog2(ROUND_WORDS) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] LAST = WW'(ROUND_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [127:0]  shreg;
  logic [3:0]    byte_idx;
  logic [WW-1:0] word_idx;
  state_t        state;
  logic          in_en_q;
  logic [7:0]    iot_q;
  logic          done_q;
  logic          push;
  logic          pop;

  assign bus.s_ready    = (count < FULL) && rst;
  assign bus.in_en      = in_en_q;
  assign bus.iot_in     = iot_q;
  assign bus.round_done = done_q;
  assign bus.active     = (state == SEND);

  assign push = bus.s_valid && bus.s_ready;
  assign pop  = (state == IDLE) && (count != '0) && !bus.busy;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // shreg keeps the not-yet-sent bytes left-aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      in_en_q  <= 1'b0;
      iot_q    <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (pop) begin
            shreg    <= mem[rd_ptr] << 8;
            iot_q    <= mem[rd_ptr][127:120];
            in_en_q  <= 1'b1;
            byte_idx <= 4'd1;
            state    <= SEND;
          end else begin
            in_en_q <= 1'b0;
          end
        end
        SEND: begin
          if (!bus.busy) begin
            in_en_q  <= 1'b1;
            iot_q    <= shreg[127:120];
            shreg    <= shreg << 8;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 4'd15) begin
              state    <= IDLE;
              done_q   <= (word_idx == LAST);
              word_idx <= (word_idx == LAST) ? '0 : word_idx + 1'b1;
            end else begin
              done_q <= 1'b0;
            end
          end else begin
            in_en_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iot_feeder.sv
// Directed bench for iot_feeder: vector table for one word with
// a pause, then full-FIFO, reset, round and push/pop sequences.
module tb_iot_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iot_feeder_if bus ();

  iot_feeder #(.DEPTH(4), .ROUND_WORDS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       busy;
    logic       en;
    logic [7:0] d;
    logic       act;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0]   got_q [$];
  logic [7:0]   exp_q [$];
  logic [127:0] src_q [$];
  int           rd_q  [$];
  int           n_got;
  int           gaps;

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mkword(int base);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++)
      w[127-8*k -: 8] = 8'(base + k);
    return w;
  endfunction

  task automatic add_exp(logic [127:0] w, int from);
    for (int k = from; k < 16; k++)
      exp_q.push_back(w[127-8*k -: 8]);
  endtask

  // Runs the source from src_q while gathering up to n strobes.
  task automatic collect(int n, int budget);
    logic acc;
    got_q.delete();
    rd_q.delete();
    n_got = 0;
    gaps  = 0;
    for (int c = 0; c < budget && n_got < n; c++) begin
      if (!bus.s_valid && src_q.size() > 0) begin
        bus.s_valid = 1'b1;
        bus.s_data  = src_q.pop_front();
      end
      acc = bus.s_valid && bus.s_ready;
      step();
      if (acc)
        bus.s_valid = 1'b0;
      if (bus.in_en) begin
        got_q.push_back(bus.iot_in);
        n_got++;
        if (bus.round_done)
          rd_q.push_back(n_got);
      end else if (n_got > 0) begin
        gaps++;
      end
    end
  endtask

  task automatic cmp_bytes(string name);
    int m;
    m = 0;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i])
        m++;
    chk({name, "_bytes"}, m, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  vec_t tv [20];
  logic [127:0] w;
  logic [127:0] p [5];

  initial begin
    tv[0]  = '{1'b0, 1'b1, 8'h00, 1'b1};
    tv[1]  = '{1'b0, 1'b1, 8'h11, 1'b1};
    tv[2]  = '{1'b0, 1'b1, 8'h22, 1'b1};
    tv[3]  = '{1'b0, 1'b1, 8'h33, 1'b1};
    tv[4]  = '{1'b0, 1'b1, 8'h44, 1'b1};
    tv[5]  = '{1'b0, 1'b1, 8'h55, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 8'h55, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 8'h55, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 8'h55, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 8'h66, 1'b1};
    tv[10] = '{1'b0, 1'b1, 8'h77, 1'b1};
    tv[11] = '{1'b0, 1'b1, 8'h88, 1'b1};
    tv[12] = '{1'b0, 1'b1, 8'h99, 1'b1};
    tv[13] = '{1'b0, 1'b1, 8'hAA, 1'b1};
    tv[14] = '{1'b0, 1'b1, 8'hBB, 1'b1};
    tv[15] = '{1'b0, 1'b1, 8'hCC, 1'b1};
    tv[16] = '{1'b0, 1'b1, 8'hDD, 1'b1};
    tv[17] = '{1'b0, 1'b1, 8'hEE, 1'b1};
    tv[18] = '{1'b0, 1'b1, 8'hFF, 1'b0};
    tv[19] = '{1'b0, 1'b0, 8'hFF, 1'b0};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.busy    = 1'b0;

    #2 rst = 1'b0;
    #20;
    chk("rst_in_en", bus.in_en, 1'b0);
    chk("rst_iot_in", bus.iot_in, 8'h00);
    chk("rst_round_done", bus.round_done, 1'b0);
    chk("rst_active", bus.active, 1'b0);
    chk("rst_s_ready", bus.s_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("post_rst_s_ready", bus.s_ready, 1'b1);

    // single word with a three-cycle pause after byte 5
    w = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    step();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.busy = tv[i].busy;
      step();
      chk($sformatf("vec%0d_in_en", i), bus.in_en, tv[i].en);
      chk($sformatf("vec%0d_iot_in", i), bus.iot_in, tv[i].d);
      chk($sformatf("vec%0d_active", i), bus.active, tv[i].act);
      chk($sformatf("vec%0d_round_done", i), bus.round_done, 1'b0);
    end

    // full FIFO under backpressure, fifth word held by source
    bus.busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      p[i] = mkword(32 * (i + 1));
      add_exp(p[i], 0);
      bus.s_valid = 1'b1;
      bus.s_data  = p[i];
      chk($sformatf("fill%0d_ready", i), bus.s_ready, 1'b1);
      step();
    end
    p[4] = mkword(8'hA0);
    add_exp(p[4], 0);
    bus.s_data = p[4];
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("full%0d_ready", i), bus.s_ready, 1'b0);
      chk($sformatf("full%0d_in_en", i), bus.in_en, 1'b0);
      step();
    end
    bus.busy = 1'b0;
    collect(80, 300);
    chk("full_strobes", n_got, 80);
    cmp_bytes("full");
    chk("full_rd_pulses", rd_q.size(), 0);

    // reset in the middle of a word with more words queued
    src_q.delete();
    for (int i = 0; i < 3; i++)
      src_q.push_back(mkword(8'h50 + 16 * i));
    collect(10, 60);
    chk("mid_strobes", n_got, 10);
    chk("mid_byte9", bus.iot_in, 8'h59);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    src_q.delete();
    #1;
    chk("mid_rst_in_en", bus.in_en, 1'b0);
    chk("mid_rst_s_ready", bus.s_ready, 1'b0);
    chk("mid_rst_iot_in", bus.iot_in, 8'h00);
    chk("mid_rst_active", bus.active, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    w = mkword(8'hC0);
    exp_q.delete();
    add_exp(w, 0);
    src_q.push_back(w);
    collect(16, 40);
    chk("new_strobes", n_got, 16);
    cmp_bytes("new_word");
    collect(1, 30);
    chk("stale_strobes", n_got, 0);

    // one full round plus a second: 16 words, 256 strobes
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      src_q.push_back(mkword(16 * i));
      add_exp(mkword(16 * i), 0);
    end
    collect(256, 600);
    chk("round_strobes", n_got, 256);
    chk("round_gaps", gaps, 0);
    cmp_bytes("round");
    chk("round_pulses", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      chk("round_pulse_a", rd_q[0], 128);
      chk("round_pulse_b", rd_q[1], 256);
    end

    // push and pop on the same edge with three words stored
    bus.busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++)
      p[i] = mkword(8'h08 + 40 * i);
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = p[i];
      step();
    end
    bus.s_data = p[3];
    bus.busy   = 1'b0;
    chk("pp_ready_before", bus.s_ready, 1'b1);
    step();
    bus.s_valid = 1'b0;
    bus.busy    = 1'b1;
    chk("pp_ready_after", bus.s_ready, 1'b1);
    chk("pp_in_en", bus.in_en, 1'b1);
    chk("pp_byte0", bus.iot_in, p[0][127:120]);
    bus.s_valid = 1'b1;
    bus.s_data  = p[4];
    step();
    bus.s_valid = 1'b0;
    chk("pp_full_ready", bus.s_ready, 1'b0);
    add_exp(p[0], 1);
    for (int i = 1; i < 5; i++)
      add_exp(p[i], 0);
    bus.busy = 1'b0;
    collect(79, 300);
    chk("pp_strobes", n_got, 79);
    cmp_bytes("pp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
